// File: rtl/mc_cu_pkg.sv
// Shared constants for the multicycle control unit: state codes, opcode
// classes, writeback / PC source select codes, ALU op codes and the branch
// condition helper.
package mc_cu_pkg;

    // State encodings (5-bit, matching the debug state port)
    localparam logic [4:0] ST_IDLE     = 5'd0;
    localparam logic [4:0] ST_FETCH    = 5'd1;
    localparam logic [4:0] ST_DECODE   = 5'd2;
    localparam logic [4:0] ST_EXEC_R   = 5'd3;
    localparam logic [4:0] ST_WB       = 5'd4;
    localparam logic [4:0] ST_EXEC_I   = 5'd5;
    localparam logic [4:0] ST_LUI_WB   = 5'd6;
    localparam logic [4:0] ST_MEM_ADDR = 5'd7;
    localparam logic [4:0] ST_MEM_RD   = 5'd8;
    localparam logic [4:0] ST_LD_WB    = 5'd9;
    localparam logic [4:0] ST_MEM_WR   = 5'd10;
    localparam logic [4:0] ST_BRANCH   = 5'd11;
    localparam logic [4:0] ST_BR_UPD   = 5'd12;
    localparam logic [4:0] ST_JAL      = 5'd13;
    localparam logic [4:0] ST_ERROR    = 5'd31;

    // Opcode classes (IR[6:0])
    localparam logic [6:0] OPC_R     = 7'b0110011;
    localparam logic [6:0] OPC_I     = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_BR    = 7'b1100011;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;

    // Writeback source select
    localparam logic [1:0] WD_F   = 2'd0;
    localparam logic [1:0] WD_IMM = 2'd1;
    localparam logic [1:0] WD_MEM = 2'd2;
    localparam logic [1:0] WD_PC4 = 2'd3;

    // PC source select
    localparam logic PC_S_PC4 = 1'b0;
    localparam logic PC_S_TGT = 1'b1;

    // ALU op codes used directly by the controller
    localparam logic [3:0] ALU_OP_ADD = 4'b0000;
    localparam logic [3:0] ALU_OP_SUB = 4'b1000;

    // Branch condition: BEQ taken on zero, BNE taken on non-zero, others never
    function automatic logic br_taken(input logic [2:0] funct3, input logic zf);
        logic taken;
        case (funct3)
            3'b000:  taken = zf;
            3'b001:  taken = ~zf;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/mc_cu_if.sv
// Instruction-field / status inputs and control outputs of the control unit.
// The slave side is the control unit, the master side is its environment.
interface mc_cu_if #(
    parameter int ALU_OP_W = 4,
    parameter int ST_W     = 5
) ();
    logic [6:0]          opcode;
    logic [2:0]          funct3;
    logic                funct7_5;
    logic                ZF;
    logic                mem_ready;

    logic                PC_Write;
    logic                IR_Write;
    logic                Reg_Write;
    logic                Mem_Read;
    logic                Mem_Write;
    logic                rs2_imm_s;
    logic [1:0]          w_data_s;
    logic                pc_s;
    logic [ALU_OP_W-1:0] ALU_OP_o;
    logic                err;
    logic [ST_W-1:0]     state;

    modport slave (
        input  opcode, funct3, funct7_5, ZF, mem_ready,
        output PC_Write, IR_Write, Reg_Write, Mem_Read, Mem_Write,
               rs2_imm_s, w_data_s, pc_s, ALU_OP_o, err, state
    );

    modport master (
        output opcode, funct3, funct7_5, ZF, mem_ready,
        input  PC_Write, IR_Write, Reg_Write, Mem_Read, Mem_Write,
               rs2_imm_s, w_data_s, pc_s, ALU_OP_o, err, state
    );
endinterface

// File: rtl/mc_cu_decode.sv
// Combinational opcode classification and ALU op generation.
module mc_cu_decode
    import mc_cu_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output logic       is_r,
    output logic       is_i,
    output logic       is_lui,
    output logic       is_load,
    output logic       is_store,
    output logic       is_br,
    output logic       is_jal,
    output logic       illegal,
    output logic [3:0] alu_op
);

    // Classify the opcode and form the ALU op; shifts-right in the I class
    // keep funct7_5 to distinguish SRAI from SRLI, others ignore it
    always_comb begin
        is_r     = 1'b0;
        is_i     = 1'b0;
        is_lui   = 1'b0;
        is_load  = 1'b0;
        is_store = 1'b0;
        is_br    = 1'b0;
        is_jal   = 1'b0;
        illegal  = 1'b0;
        alu_op   = ALU_OP_ADD;
        case (opcode)
            OPC_R: begin
                is_r   = 1'b1;
                alu_op = {funct7_5, funct3};
            end
            OPC_I: begin
                is_i = 1'b1;
                if (funct3 == 3'b101) begin
                    alu_op = {funct7_5, funct3};
                end else begin
                    alu_op = {1'b0, funct3};
                end
            end
            OPC_LUI:   is_lui   = 1'b1;
            OPC_LOAD:  is_load  = 1'b1;
            OPC_STORE: is_store = 1'b1;
            OPC_BR:    is_br    = 1'b1;
            OPC_JAL:   is_jal   = 1'b1;
            default:   illegal  = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_cu.sv
// Multicycle control unit: R/I/LUI/LOAD/STORE/BEQ/BNE/JAL sequencing with a
// bounded memory wait and a sticky error state. All outputs are registered
// from the next state so they are stable for the whole state they belong to.
module mc_cu
    import mc_cu_pkg::*;
#(
    parameter int ALU_OP_W    = 4,
    parameter int ST_W        = 5,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic    clk,
    input  logic    rst_n,
    mc_cu_if.slave  bus
);

    localparam logic [7:0] TIMEOUT_C = 8'(MEM_TIMEOUT);

    // Decoder outputs
    logic       dec_is_r_s;
    logic       dec_is_i_s;
    logic       dec_is_lui_s;
    logic       dec_is_load_s;
    logic       dec_is_store_s;
    logic       dec_is_br_s;
    logic       dec_is_jal_s;
    logic       dec_illegal_s;
    logic [3:0] dec_alu_op_s;

    // State and wait counter
    logic [4:0] st_d,  st_q;
    logic [7:0] cnt_d, cnt_q;
    logic       in_mem_s;
    logic       enter_mem_s;

    // Registered outputs
    logic                pc_write_d,  pc_write_q;
    logic                ir_write_d,  ir_write_q;
    logic                reg_write_d, reg_write_q;
    logic                mem_read_d,  mem_read_q;
    logic                mem_write_d, mem_write_q;
    logic                rs2_imm_d,   rs2_imm_q;
    logic [1:0]          w_data_d,    w_data_q;
    logic                pc_sel_d,    pc_sel_q;
    logic [ALU_OP_W-1:0] alu_op_d,    alu_op_q;
    logic                err_d,       err_q;

    mc_cu_decode u_decode (
        .opcode   (bus.opcode),
        .funct3   (bus.funct3),
        .funct7_5 (bus.funct7_5),
        .is_r     (dec_is_r_s),
        .is_i     (dec_is_i_s),
        .is_lui   (dec_is_lui_s),
        .is_load  (dec_is_load_s),
        .is_store (dec_is_store_s),
        .is_br    (dec_is_br_s),
        .is_jal   (dec_is_jal_s),
        .illegal  (dec_illegal_s),
        .alu_op   (dec_alu_op_s)
    );

    assign in_mem_s = (st_q == ST_MEM_RD) || (st_q == ST_MEM_WR);

    // Next-state selection
    always_comb begin
        st_d = st_q;
        case (st_q)
            ST_IDLE:  st_d = ST_FETCH;
            ST_FETCH: begin
                if (dec_is_lui_s) begin
                    st_d = ST_LUI_WB;
                end else if (dec_is_jal_s) begin
                    st_d = ST_JAL;
                end else begin
                    st_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (dec_is_r_s) begin
                    st_d = ST_EXEC_R;
                end else if (dec_is_i_s) begin
                    st_d = ST_EXEC_I;
                end else if (dec_is_load_s || dec_is_store_s) begin
                    st_d = ST_MEM_ADDR;
                end else if (dec_is_br_s) begin
                    st_d = ST_BRANCH;
                end else begin
                    // illegal opcode, or a class that never reaches DECODE
                    st_d = ST_ERROR;
                end
            end
            ST_EXEC_R: st_d = ST_WB;
            ST_EXEC_I: st_d = ST_WB;
            ST_WB:     st_d = ST_FETCH;
            ST_LUI_WB: st_d = ST_FETCH;
            ST_MEM_ADDR: begin
                if (dec_is_load_s) begin
                    st_d = ST_MEM_RD;
                end else if (dec_is_store_s) begin
                    st_d = ST_MEM_WR;
                end else begin
                    st_d = ST_ERROR;
                end
            end
            ST_MEM_RD: begin
                if (bus.mem_ready) begin
                    st_d = ST_LD_WB;
                end else if (cnt_q == TIMEOUT_C) begin
                    st_d = ST_ERROR;
                end else begin
                    st_d = ST_MEM_RD;
                end
            end
            ST_MEM_WR: begin
                if (bus.mem_ready) begin
                    st_d = ST_FETCH;
                end else if (cnt_q == TIMEOUT_C) begin
                    st_d = ST_ERROR;
                end else begin
                    st_d = ST_MEM_WR;
                end
            end
            ST_LD_WB:  st_d = ST_FETCH;
            ST_BRANCH: st_d = ST_BR_UPD;
            ST_BR_UPD: st_d = ST_FETCH;
            ST_JAL:    st_d = ST_FETCH;
            ST_ERROR:  st_d = ST_ERROR;
            default:   st_d = ST_ERROR;
        endcase
    end

    assign enter_mem_s = ((st_d == ST_MEM_RD) || (st_d == ST_MEM_WR)) && !in_mem_s;

    // Memory wait counter: cleared on entry, counts cycles without mem_ready
    always_comb begin
        if (enter_mem_s) begin
            cnt_d = 8'd0;
        end else if (in_mem_s && !bus.mem_ready) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Output values for the state being entered; mux selects hold by default
    always_comb begin
        pc_write_d  = 1'b0;
        ir_write_d  = 1'b0;
        reg_write_d = 1'b0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        err_d       = 1'b0;
        rs2_imm_d   = rs2_imm_q;
        w_data_d    = w_data_q;
        pc_sel_d    = pc_sel_q;
        alu_op_d    = alu_op_q;
        case (st_d)
            ST_FETCH: begin
                pc_write_d = 1'b1;
                ir_write_d = 1'b1;
                pc_sel_d   = PC_S_PC4;
            end
            ST_EXEC_R: begin
                alu_op_d  = ALU_OP_W'(dec_alu_op_s);
                rs2_imm_d = 1'b0;
            end
            ST_EXEC_I: begin
                alu_op_d  = ALU_OP_W'(dec_alu_op_s);
                rs2_imm_d = 1'b1;
            end
            ST_WB: begin
                reg_write_d = 1'b1;
                w_data_d    = WD_F;
            end
            ST_LUI_WB: begin
                reg_write_d = 1'b1;
                w_data_d    = WD_IMM;
            end
            ST_MEM_ADDR: begin
                alu_op_d  = ALU_OP_W'(ALU_OP_ADD);
                rs2_imm_d = 1'b1;
            end
            ST_MEM_RD: mem_read_d  = 1'b1;
            ST_MEM_WR: mem_write_d = 1'b1;
            ST_LD_WB: begin
                reg_write_d = 1'b1;
                w_data_d    = WD_MEM;
            end
            ST_BRANCH: begin
                alu_op_d  = ALU_OP_W'(ALU_OP_SUB);
                rs2_imm_d = 1'b0;
            end
            ST_BR_UPD: begin
                // ZF/funct3 sampled on the edge leaving BRANCH
                pc_write_d = br_taken(bus.funct3, bus.ZF);
                pc_sel_d   = PC_S_TGT;
            end
            ST_JAL: begin
                reg_write_d = 1'b1;
                w_data_d    = WD_PC4;
                pc_write_d  = 1'b1;
                pc_sel_d    = PC_S_TGT;
            end
            ST_ERROR: err_d = 1'b1;
            default: begin
                pc_write_d = 1'b0;
            end
        endcase
    end

    // State, counter and output registers; reset drops any in-flight request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q        <= ST_IDLE;
            cnt_q       <= 8'd0;
            pc_write_q  <= 1'b0;
            ir_write_q  <= 1'b0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            rs2_imm_q   <= 1'b0;
            w_data_q    <= 2'd0;
            pc_sel_q    <= 1'b0;
            alu_op_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            st_q        <= st_d;
            cnt_q       <= cnt_d;
            pc_write_q  <= pc_write_d;
            ir_write_q  <= ir_write_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            rs2_imm_q   <= rs2_imm_d;
            w_data_q    <= w_data_d;
            pc_sel_q    <= pc_sel_d;
            alu_op_q    <= alu_op_d;
            err_q       <= err_d;
        end
    end

    assign bus.PC_Write  = pc_write_q;
    assign bus.IR_Write  = ir_write_q;
    assign bus.Reg_Write = reg_write_q;
    assign bus.Mem_Read  = mem_read_q;
    assign bus.Mem_Write = mem_write_q;
    assign bus.rs2_imm_s = rs2_imm_q;
    assign bus.w_data_s  = w_data_q;
    assign bus.pc_s      = pc_sel_q;
    assign bus.ALU_OP_o  = alu_op_q;
    assign bus.err       = err_q;
    assign bus.state     = ST_W'(st_q);

endmodule
